// File: rtl/matrix_pkg.sv
// Shared defaults, counter-width helper and state encoding for the 3x3 window generator.
package matrix_pkg;

    localparam int IMG_W_DEF = 480;
    localparam int IMG_H_DEF = 272;
    localparam int DW_DEF    = 8;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int X_W_DEF = cnt_w(IMG_W_DEF);
    localparam int Y_W_DEF = cnt_w(IMG_H_DEF);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

endpackage

// File: rtl/line_ram.sv
// One line of pixel storage: single address, read returns the contents before this cycle's write.
module line_ram
    import matrix_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = X_W_DEF
) (
    input  logic          sclk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    always_comb dout = mem[addr];

    always_ff @(posedge sclk) begin
        if (we) mem[addr] <= din;
    end

endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 sliding window over a raster stream, two-cycle fixed latency.
// MATRIX_BORDER_REPLICATE_EN: out-of-frame rows/columns copy the nearest edge instead of reading 0.
module matrix_3x3_gen
    import matrix_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          sclk,
    input  logic          s_rst,
    input  logic          vsync,
    input  logic          data_valuable,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] matrix_p11,
    output logic [DW-1:0] matrix_p12,
    output logic [DW-1:0] matrix_p13,
    output logic [DW-1:0] matrix_p21,
    output logic [DW-1:0] matrix_p22,
    output logic [DW-1:0] matrix_p23,
    output logic [DW-1:0] matrix_p31,
    output logic [DW-1:0] matrix_p32,
    output logic [DW-1:0] matrix_p33,
    output logic          dout_flag,
    output logic          frame_done
);

    localparam int XW = cnt_w(IMG_W);
    localparam int YW = cnt_w(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_t        state;
    logic          vsync_d;
    logic [XW-1:0] col_cnt;
    logic [YW-1:0] row_cnt;

    logic          vs_rise;
    logic          pix_take;
    logic          pix_last;
    logic [XW-1:0] cur_col;
    logic [YW-1:0] cur_row;

    logic [DW-1:0] l1_q;
    logic [DW-1:0] l0_q;

    // A vsync rise re-bases the coordinate of a pixel arriving in the same cycle.
    always_comb begin
        vs_rise  = vsync && !vsync_d;
        pix_take = data_valuable && (vs_rise || (state == ACTIVE));
        cur_col  = vs_rise ? '0 : col_cnt;
        cur_row  = vs_rise ? '0 : row_cnt;
        pix_last = (cur_col == X_LAST) && (cur_row == Y_LAST);
    end

    line_ram #(
        .DEPTH (IMG_W),
        .DW    (DW),
        .AW    (XW)
    ) u_line1 (
        .sclk (sclk),
        .we   (pix_take),
        .addr (cur_col),
        .din  (din),
        .dout (l1_q)
    );

    line_ram #(
        .DEPTH (IMG_W),
        .DW    (DW),
        .AW    (XW)
    ) u_line0 (
        .sclk (sclk),
        .we   (pix_take),
        .addr (cur_col),
        .din  (l1_q),
        .dout (l0_q)
    );

    // vsync_d resets high so a vsync already high at release is not taken as a frame start.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state   <= IDLE;
            vsync_d <= 1'b1;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            vsync_d <= vsync;
            if (pix_take) begin
                if (cur_col == X_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (cur_row == Y_LAST) ? '0 : cur_row + YW'(1);
                end else begin
                    col_cnt <= cur_col + XW'(1);
                    row_cnt <= cur_row;
                end
                state <= pix_last ? DONE : ACTIVE;
            end else if (vs_rise) begin
                col_cnt <= '0;
                row_cnt <= '0;
                state   <= ACTIVE;
            end
        end
    end

    logic          s1_vld;
    logic          s1_done;
    logic [DW-1:0] s1_pix;
    logic [DW-1:0] s1_mid;
    logic [DW-1:0] s1_top;
    logic          s1_x0;
    logic          s1_x1;
    logic          s1_y0;
    logic          s1_y1;

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            s1_vld  <= 1'b0;
            s1_done <= 1'b0;
            s1_pix  <= '0;
            s1_mid  <= '0;
            s1_top  <= '0;
            s1_x0   <= 1'b0;
            s1_x1   <= 1'b0;
            s1_y0   <= 1'b0;
            s1_y1   <= 1'b0;
        end else begin
            s1_vld  <= pix_take;
            s1_done <= pix_take && pix_last;
            if (pix_take) begin
                s1_pix <= din;
                s1_mid <= l1_q;
                s1_top <= l0_q;
                s1_x0  <= (cur_col == '0);
                s1_x1  <= (cur_col == XW'(1));
                s1_y0  <= (cur_row == '0);
                s1_y1  <= (cur_row == YW'(1));
            end
        end
    end

    logic [DW-1:0]   mid_e;
    logic [DW-1:0]   top_e;
    logic [3*DW-1:0] old_c2;
    logic [3*DW-1:0] old_c3;
    logic [3*DW-1:0] c1_n;
    logic [3*DW-1:0] c2_n;
    logic [3*DW-1:0] c3_n;

    // Columns are {top, mid, bottom}; rows are masked on entry, columns on the shift.
    always_comb begin
        old_c2 = {matrix_p12, matrix_p22, matrix_p32};
        old_c3 = {matrix_p13, matrix_p23, matrix_p33};
`ifdef MATRIX_BORDER_REPLICATE_EN
        mid_e = s1_y0 ? s1_pix : s1_mid;
        top_e = (s1_y0 || s1_y1) ? mid_e : s1_top;
        c3_n  = {top_e, mid_e, s1_pix};
        c2_n  = s1_x0 ? c3_n : old_c3;
        c1_n  = s1_x0 ? c3_n : (s1_x1 ? old_c3 : old_c2);
`else
        mid_e = s1_y0 ? '0 : s1_mid;
        top_e = (s1_y0 || s1_y1) ? '0 : s1_top;
        c3_n  = {top_e, mid_e, s1_pix};
        c2_n  = s1_x0 ? '0 : old_c3;
        c1_n  = (s1_x0 || s1_x1) ? '0 : old_c2;
`endif
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            dout_flag  <= 1'b0;
            frame_done <= 1'b0;
            matrix_p11 <= '0;
            matrix_p12 <= '0;
            matrix_p13 <= '0;
            matrix_p21 <= '0;
            matrix_p22 <= '0;
            matrix_p23 <= '0;
            matrix_p31 <= '0;
            matrix_p32 <= '0;
            matrix_p33 <= '0;
        end else begin
            dout_flag  <= s1_vld;
            frame_done <= s1_done;
            if (s1_vld) begin
                {matrix_p11, matrix_p21, matrix_p31} <= c1_n;
                {matrix_p12, matrix_p22, matrix_p32} <= c2_n;
                {matrix_p13, matrix_p23, matrix_p33} <= c3_n;
            end
        end
    end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen on a small 8x6 image; border mode follows MATRIX_BORDER_REPLICATE_EN.
module tb_matrix_3x3_gen;

    localparam int TW = 8;
    localparam int TH = 6;
    localparam int DW = 8;

    logic          sclk = 1'b0;
    logic          s_rst = 1'b0;
    logic          vsync = 1'b0;
    logic          data_valuable = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
    logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
    logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;
    logic          dout_flag;
    logic          frame_done;
    logic [71:0]   win_act;

    matrix_3x3_gen #(
        .IMG_W (TW),
        .IMG_H (TH),
        .DW    (DW)
    ) dut (
        .sclk          (sclk),
        .s_rst         (s_rst),
        .vsync         (vsync),
        .data_valuable (data_valuable),
        .din           (din),
        .matrix_p11    (matrix_p11),
        .matrix_p12    (matrix_p12),
        .matrix_p13    (matrix_p13),
        .matrix_p21    (matrix_p21),
        .matrix_p22    (matrix_p22),
        .matrix_p23    (matrix_p23),
        .matrix_p31    (matrix_p31),
        .matrix_p32    (matrix_p32),
        .matrix_p33    (matrix_p33),
        .dout_flag     (dout_flag),
        .frame_done    (frame_done)
    );

    always #5 sclk = ~sclk;

    assign win_act = {matrix_p11, matrix_p12, matrix_p13,
                      matrix_p21, matrix_p22, matrix_p23,
                      matrix_p31, matrix_p32, matrix_p33};

    typedef struct {
        int          x;
        int          y;
        logic [71:0] win;
        logic        done;
        int          due;
    } exp_t;

    typedef struct {
        int          x;
        int          y;
        logic [71:0] w;
    } vec_t;

    exp_t        q[$];
    exp_t        ce;
    int          tests = 0;
    int          fails = 0;
    int          ncyc = 0;
    int          nflags = 0;
    int          npush = 0;
    int          fd_cnt = 0;
    logic [7:0]  img [TH][TW];
    logic [71:0] cap [TH][TW];
    logic [71:0] cap_ref [TH][TW];
    logic [71:0] last_win = '0;
    int          bx = 0;
    int          by = 0;
    logic        bactive = 1'b0;
    logic        vs_prev = 1'b0;

    function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference window read straight from the stored image with the border rule applied.
    function automatic logic [71:0] model_win(input int x, input int y);
        logic [71:0] w;
        int          yy;
        int          xx;
        logic [7:0]  v;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                yy = y - 2 + r;
                xx = x - 2 + c;
`ifdef MATRIX_BORDER_REPLICATE_EN
                if (yy < 0) yy = 0;
                if (xx < 0) xx = 0;
                v = img[yy][xx];
`else
                v = (yy < 0 || xx < 0) ? 8'h00 : img[yy][xx];
`endif
                w[(8 - (r * 3 + c)) * 8 +: 8] = v;
            end
        end
        return w;
    endfunction

    task automatic drive(input logic v, input logic vs, input logic [7:0] d);
        exp_t e;
        logic rise;
        @(posedge sclk);
        #1;
        vsync = vs;
        data_valuable = v;
        din = d;
        rise = vs && !vs_prev;
        vs_prev = vs;
        if (rise) begin
            bactive = 1'b1;
            bx = 0;
            by = 0;
        end
        if (v && bactive) begin
            img[by][bx] = d;
            e.x = bx;
            e.y = by;
            e.win = model_win(bx, by);
            e.done = (bx == TW - 1) && (by == TH - 1);
            e.due = ncyc + 3;
            q.push_back(e);
            npush++;
            if (bx == TW - 1) begin
                bx = 0;
                by = (by == TH - 1) ? 0 : by + 1;
            end else begin
                bx++;
            end
            if (e.done) bactive = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    // mode 0: x+16*y, mode 1: (x+y) ramp, other: random; npix < 0 runs the whole frame.
    task automatic run_frame(input int mode, input int gap_pct, input int npix);
        int         n;
        logic [7:0] d;
        n = 0;
        drive(1'b0, 1'b1, 8'h00);
        for (int y = 0; y < TH; y++) begin
            for (int x = 0; x < TW; x++) begin
                if (npix >= 0 && n >= npix) return;
                while ($urandom_range(0, 99) < gap_pct) drive(1'b0, 1'b0, 8'($urandom));
                case (mode)
                    0:       d = 8'(x + 16 * y);
                    1:       d = 8'(x + y);
                    default: d = 8'($urandom);
                endcase
                drive(1'b1, 1'b0, d);
                n++;
            end
        end
    endtask

    always @(negedge sclk) begin
        ncyc++;
        if (q.size() > 0 && q[0].due == ncyc) begin
            ce = q.pop_front();
            chk($sformatf("flag(%0d,%0d)", ce.x, ce.y), 72'(dout_flag), 72'd1);
            chk($sformatf("win(%0d,%0d)", ce.x, ce.y), win_act, ce.win);
            chk($sformatf("frame_done(%0d,%0d)", ce.x, ce.y), 72'(frame_done), 72'(ce.done));
            cap[ce.y][ce.x] = win_act;
            last_win = ce.win;
            nflags++;
        end else begin
            chk("flag_idle", 72'(dout_flag), 72'd0);
            chk("done_idle", 72'(frame_done), 72'd0);
            chk("hold", win_act, last_win);
        end
        if (frame_done) fd_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [6];
        int          fl0;
        int          p0;
        int          fd0;
        logic [71:0] exp_aa;

        tbl[0] = '{5, 3, 72'h13_14_15_23_24_25_33_34_35};
        tbl[1] = '{7, 5, 72'h35_36_37_45_46_47_55_56_57};
        tbl[2] = '{2, 2, 72'h00_01_02_10_11_12_20_21_22};
`ifdef MATRIX_BORDER_REPLICATE_EN
        tbl[3] = '{1, 0, 72'h00_00_01_00_00_01_00_00_01};
        tbl[4] = '{7, 1, 72'h05_06_07_05_06_07_15_16_17};
        tbl[5] = '{0, 4, 72'h20_20_20_30_30_30_40_40_40};
        exp_aa = {9{8'hAA}};
`else
        tbl[3] = '{1, 0, 72'h00_00_00_00_00_00_00_00_01};
        tbl[4] = '{7, 1, 72'h00_00_00_05_06_07_15_16_17};
        tbl[5] = '{0, 4, 72'h00_00_20_00_00_30_00_00_40};
        exp_aa = 72'h00_00_00_00_00_00_00_00_AA;
`endif

        #2;
        s_rst = 1'b1;
        repeat (3) @(posedge sclk);
        #1;
        chk("reset_win", win_act, 72'd0);
        chk("reset_flag", 72'(dout_flag), 72'd0);
        chk("reset_done", 72'(frame_done), 72'd0);
        s_rst = 1'b0;

        // Pixels before any vsync rise must be ignored.
        repeat (5) drive(1'b1, 1'b0, 8'($urandom));

        fl0 = nflags;
        fd0 = fd_cnt;
        run_frame(0, 0, -1);
        idle(4);
        chk("frameA_count", 72'(nflags - fl0), 72'(TW * TH));
        chk("frameA_done_cnt", 72'(fd_cnt - fd0), 72'd1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("tbl(%0d,%0d)", tbl[i].x, tbl[i].y), cap[tbl[i].y][tbl[i].x], tbl[i].w);
        cap_ref = cap;

        // DONE state: data without a new vsync rise is ignored.
        repeat (5) drive(1'b1, 1'b0, 8'($urandom));

        fl0 = nflags;
        p0 = npush;
        run_frame(0, 40, -1);
        idle(4);
        chk("gap_count", 72'(nflags - fl0), 72'(npush - p0));
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++)
                chk($sformatf("gap_vs_cont(%0d,%0d)", x, y), cap[y][x], cap_ref[y][x]);

        fd0 = fd_cnt;
        run_frame(1, 0, -1);
        idle(4);
        chk("ramp_done_cnt", 72'(fd_cnt - fd0), 72'd1);

        // vsync rise together with the first pixel, then a short frame aborted by vsync.
        fd0 = fd_cnt;
        drive(1'b1, 1'b1, 8'hAA);
        idle(3);
        chk("corner_00_AA", cap[0][0], exp_aa);
        repeat (19) drive(1'b1, 1'b0, 8'($urandom));
        run_frame(2, 0, -1);
        idle(4);
        chk("abort_done_cnt", 72'(fd_cnt - fd0), 72'd1);

        // Reset in the middle of line 1.
        run_frame(0, 0, 11);
        @(posedge sclk);
        #1;
        s_rst = 1'b1;
        q.delete();
        bactive = 1'b0;
        last_win = '0;
        #1;
        chk("midrst_win", win_act, 72'd0);
        chk("midrst_flag", 72'(dout_flag), 72'd0);
        chk("midrst_done", 72'(frame_done), 72'd0);
        repeat (2) @(posedge sclk);
        #1;
        s_rst = 1'b0;
        repeat (5) drive(1'b1, 1'b0, 8'($urandom));
        fl0 = nflags;
        fd0 = fd_cnt;
        run_frame(2, 20, -1);
        idle(4);
        chk("post_rst_count", 72'(nflags - fl0), 72'(TW * TH));
        chk("post_rst_done_cnt", 72'(fd_cnt - fd0), 72'd1);

        chk("queue_drained", 72'(q.size()), 72'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_3x3_gen.md
MATRIX_3X3_GEN -- requirements
Module: matrix_3x3_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 480, meaning active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 272, meaning active lines per frame.
REQ-003 SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-004 SHALL have port sclk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port s_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port vsync  input  1  frame sync; its rising edge starts a new frame.
REQ-007 SHALL have port data_valuable  input  1  input pixel strobe, one pixel per high cycle.
REQ-008 SHALL have port din  input  DW  input pixel, raster order.
REQ-009 SHALL have ports matrix_p11..matrix_p33  output  DW each  3x3 window, row1 = oldest line, column 1 = oldest pixel.
REQ-010 SHALL have port dout_flag  output  1  window valid strobe, feeds downstream median filter data_valuable.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse with the window of the last pixel (IMG_W-1, IMG_H-1).

Function
REQ-012 SHALL emit exactly one window per accepted pixel, so a frame yields IMG_W*IMG_H windows.
REQ-013 SHALL, for the pixel at (x,y), output window rows y-2, y-1, y and columns x-2, x-1, x; the pixel itself is matrix_p33.
REQ-014 SHALL assert dout_flag exactly 2 sclk cycles after the data_valuable cycle that carried the pixel; latency is fixed.
REQ-015 SHALL hold all window outputs and drive dout_flag low in cycles without a pending pixel; gaps in data_valuable stall nothing but the strobe.
REQ-016 SHALL keep column counter 0..IMG_W-1 and row counter 0..IMG_H-1, advancing only on data_valuable; the column wraps to 0 and the row increments at IMG_W-1.
REQ-017 SHALL use states IDLE (after reset, waiting for vsync rise), ACTIVE (accepting pixels) and DONE (IMG_W*IMG_H pixels taken); IDLE->ACTIVE and DONE->ACTIVE on vsync rising edge; ACTIVE->DONE on the last pixel.
REQ-018 SHALL ignore data_valuable in IDLE and DONE: no counter change, no dout_flag.
REQ-019 SHALL, on a vsync rising edge in ACTIVE (short frame), clear both counters and restart at (0,0); windows already in the pipeline still complete.
REQ-020 SHALL, on a vsync rise coincident with data_valuable, treat that pixel as (0,0) of the new frame.
REQ-021 SHALL keep two line stores of depth IMG_W, read and written at the column address in the same cycle, read-before-write, cascading din -> line1 -> line0.
REQ-022 SHALL fill out-of-frame positions (row index <0 or column index <0) per REQ-026; contents left from a previous frame SHALL never appear.

Reset
REQ-023 SHALL, while s_rst is high, force state IDLE, both counters 0, all matrix_p outputs 0, and dout_flag and frame_done 0.
REQ-024 SHALL, on reset mid-frame, discard the pipeline; line store contents need not be cleared, because REQ-022 masks them.
REQ-025 SHALL release reset asynchronously-asserted and synchronously-deasserted externally; the block needs no internal synchronizer.

Configuration
REQ-026 SHALL use macro MATRIX_BORDER_REPLICATE_EN: when defined, an out-of-frame row or column copies the nearest in-frame row or column; when undefined, it reads as 0.

Structure
REQ-027 SHALL place default IMG_W, IMG_H, DW, derived counter widths and the state enumeration in shared package matrix_pkg.
REQ-028 SHALL implement each line store as sub-module line_ram (1 read-first port, depth IMG_W, width DW), instantiated twice.

Verification
REQ-029 SHALL cover: a 480x272 ramp frame with din = (x+y)&0xFF -> 130560 dout_flag pulses, each 2 cycles after its input, and frame_done on the last pulse.
REQ-030 SHALL cover: a pixel at (5,3) with din = x+16*y -> matrix_p11=0x13, p22=0x24, p33=0x35.
REQ-031 SHALL cover: pixel (0,0) = 0xAA -> with the macro defined, all nine outputs are 0xAA; with it undefined, p33=0xAA and the other eight are 0.
REQ-032 SHALL cover: data_valuable toggled 1-0-1 at random -> outputs identical to the continuous-stream run, and dout_flag count equals input count.
REQ-033 SHALL cover: vsync rising at pixel 1000 of a frame -> the next pixel is (0,0), rows from the old frame are masked, and there is no frame_done for the aborted frame.
REQ-034 SHALL cover: s_rst pulsed mid-line -> all outputs 0 immediately, data ignored until the next vsync rise, and the following frame correct.
